// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination (rt) is read by the decode instruction
// forces a bubble into EX and raises stall_out for one cycle.
// Optional feature: define ID_EX_STALL_CNT_EN to add a saturating 16-bit
// stall_count output that counts hazard bubbles (flush bubbles excluded).
module id_ex_latch #(
    parameter int unsigned EXEC_BUS_WIDTH = 7,
    parameter int unsigned MEM_BUS_WIDTH  = 3,
    parameter int unsigned WB_BUS_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [EXEC_BUS_WIDTH-1:0] execute_bus_in,
    input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
    input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs_in,
    input  logic [REG_ADDR_WIDTH-1:0] rt_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic [DATA_WIDTH-1:0]     read_data_1_in,
    input  logic [DATA_WIDTH-1:0]     read_data_2_in,
    input  logic [DATA_WIDTH-1:0]     imm_ext_in,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_in,
    output logic [EXEC_BUS_WIDTH-1:0] execute_bus_out,
    output logic [MEM_BUS_WIDTH-1:0]  memory_bus_out,
    output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
    output logic [REG_ADDR_WIDTH-1:0] rs_out,
    output logic [REG_ADDR_WIDTH-1:0] rt_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic [DATA_WIDTH-1:0]     read_data_1_out,
    output logic [DATA_WIDTH-1:0]     read_data_2_out,
    output logic [DATA_WIDTH-1:0]     imm_ext_out,
    output logic [DATA_WIDTH-1:0]     pc_plus4_out,
    output logic                      stall_out
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]               stall_count
`endif
);

    logic hazard;
    logic bubble;

    // Load-use detection against the instruction now in EX; register zero never stalls.
    always_comb begin
        hazard    = memory_bus_out[1] && (rt_out != '0) &&
                    ((rt_out == rs_in) || (rt_out == rt_in));
        bubble    = flush || hazard;
        stall_out = hazard && !flush && enable;
    end

    // Pipeline register: hold when disabled, zero control fields on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            execute_bus_out <= '0;
            memory_bus_out  <= '0;
            wb_bus_out      <= '0;
            rs_out          <= '0;
            rt_out          <= '0;
            rd_out          <= '0;
            read_data_1_out <= '0;
            read_data_2_out <= '0;
            imm_ext_out     <= '0;
            pc_plus4_out    <= '0;
        end else if (enable) begin
            execute_bus_out <= bubble ? '0 : execute_bus_in;
            memory_bus_out  <= bubble ? '0 : memory_bus_in;
            wb_bus_out      <= bubble ? '0 : wb_bus_in;
            rs_out          <= rs_in;
            rt_out          <= rt_in;
            rd_out          <= rd_in;
            read_data_1_out <= read_data_1_in;
            read_data_2_out <= read_data_2_in;
            imm_ext_out     <= imm_ext_in;
            pc_plus4_out    <= pc_plus4_in;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count hazard bubbles only; stall_out already excludes flush and disabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_out && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed and randomized checks of id_ex_latch against a
// behavioural model of the pipeline-register and hazard rules.
module tb_id_ex_latch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [6:0]  execute_bus_in;
    logic [2:0]  memory_bus_in;
    logic [1:0]  wb_bus_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [31:0] read_data_1_in, read_data_2_in, imm_ext_in, pc_plus4_in;
    logic [6:0]  execute_bus_out;
    logic [2:0]  memory_bus_out;
    logic [1:0]  wb_bus_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [31:0] read_data_1_out, read_data_2_out, imm_ext_out, pc_plus4_out;
    logic        stall_out;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the EX stage should currently hold.
    logic [6:0]  m_ex;
    logic [2:0]  m_mem;
    logic [1:0]  m_wb;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    int unsigned m_cnt;

    id_ex_latch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .flush           (flush),
        .execute_bus_in  (execute_bus_in),
        .memory_bus_in   (memory_bus_in),
        .wb_bus_in       (wb_bus_in),
        .rs_in           (rs_in),
        .rt_in           (rt_in),
        .rd_in           (rd_in),
        .read_data_1_in  (read_data_1_in),
        .read_data_2_in  (read_data_2_in),
        .imm_ext_in      (imm_ext_in),
        .pc_plus4_in     (pc_plus4_in),
        .execute_bus_out (execute_bus_out),
        .memory_bus_out  (memory_bus_out),
        .wb_bus_out      (wb_bus_out),
        .rs_out          (rs_out),
        .rt_out          (rt_out),
        .rd_out          (rd_out),
        .read_data_1_out (read_data_1_out),
        .read_data_2_out (read_data_2_out),
        .imm_ext_out     (imm_ext_out),
        .pc_plus4_out    (pc_plus4_out),
        .stall_out       (stall_out)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A load in EX is a "lw"; decode reads rs and rt.
    function automatic bit model_hazard();
        return m_mem[1] && (m_rt != 5'd0) && ((m_rt == rs_in) || (m_rt == rt_in));
    endfunction

    function automatic bit model_stall();
        return model_hazard() && !flush && enable;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
        m_cnt = 0;
    endtask

    // Called just after an active edge, using the inputs that were stable at the edge.
    task automatic model_edge(input bit haz);
        if (!enable) return;
        if (flush || haz) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            if (!flush && m_cnt < 32'hFFFF) m_cnt++;
        end else begin
            m_ex = execute_bus_in; m_mem = memory_bus_in; m_wb = wb_bus_in;
        end
        m_rs = rs_in; m_rt = rt_in; m_rd = rd_in;
        m_rd1 = read_data_1_in; m_rd2 = read_data_2_in;
        m_imm = imm_ext_in; m_pc = pc_plus4_in;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_ex"},  64'(execute_bus_out), 64'(m_ex));
        chk({pfx, "_mem"}, 64'(memory_bus_out),  64'(m_mem));
        chk({pfx, "_wb"},  64'(wb_bus_out),      64'(m_wb));
        chk({pfx, "_regs"}, 64'({rs_out, rt_out, rd_out}), 64'({m_rs, m_rt, m_rd}));
        chk({pfx, "_rd12"}, {read_data_1_out, read_data_2_out}, {m_rd1, m_rd2});
        chk({pfx, "_immpc"}, {imm_ext_out, pc_plus4_out}, {m_imm, m_pc});
`ifdef ID_EX_STALL_CNT_EN
        chk({pfx, "_cnt"}, 64'(stall_count), 64'(m_cnt));
`endif
    endtask

    // Inputs are set by the caller after the previous edge; check stall, clock, check state.
    task automatic step(input string pfx);
        bit haz;
        #1;
        chk({pfx, "_stall"}, 64'(stall_out), 64'(model_stall()));
        haz = model_hazard();
        @(posedge clk);
        model_edge(haz);
        #1;
        check_outputs(pfx);
    endtask

    task automatic set_inputs(input logic [6:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        execute_bus_in = ex; memory_bus_in = mem; wb_bus_in = wb;
        rs_in = rs; rt_in = rt; rd_in = rd;
        read_data_1_in = $urandom; read_data_2_in = $urandom;
        imm_ext_in = $urandom; pc_plus4_in = $urandom;
    endtask

    task automatic rand_inputs();
        set_inputs(7'($urandom), 3'($urandom), 2'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
        flush  = ($urandom_range(0, 7) == 0);
        enable = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        set_inputs(7'h11, 3'b111, 2'b11, 5'd1, 5'd2, 5'd3);
        model_reset();
        #2;
        check_outputs("por");
        chk("por_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Plain load of known values.
        set_inputs(7'h23, 3'b000, 2'b10, 5'd4, 5'd6, 5'd7);
        read_data_1_in = 32'hDEADBEEF;
        step("load");
        chk("load_ex_const", 64'(execute_bus_out), 64'h23);
        chk("load_wb_const", 64'(wb_bus_out), 64'h2);
        chk("load_rd1_const", 64'(read_data_1_out), 64'hDEADBEEF);

        // Load-use: lw to r5 then consumer of r5.
        set_inputs(7'h05, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
        step("lw5");
        set_inputs(7'h7F, 3'b001, 2'b01, 5'd5, 5'd9, 5'd10);
        #1;
        chk("ldu_stall_hi", 64'(stall_out), 64'd1);
        step("ldu_bubble");
        chk("ldu_ctrl_zero", 64'({execute_bus_out, memory_bus_out, wb_bus_out}), 64'd0);
        #1;
        chk("ldu_stall_lo", 64'(stall_out), 64'd0);
        step("ldu_resume");

        // Register zero never stalls.
        set_inputs(7'h05, 3'b010, 2'b11, 5'd1, 5'd0, 5'd0);
        step("lw0");
        set_inputs(7'h2A, 3'b100, 2'b01, 5'd0, 5'd0, 5'd3);
        #1;
        chk("zero_stall", 64'(stall_out), 64'd0);
        step("zero_load");
        chk("zero_ex_const", 64'(execute_bus_out), 64'h2A);

        // Flush and hazard together: one bubble, no stall, no count.
        set_inputs(7'h05, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
        step("lw5b");
        set_inputs(7'h3C, 3'b011, 2'b10, 5'd5, 5'd5, 5'd2);
        flush = 1'b1;
        #1;
        chk("fh_stall", 64'(stall_out), 64'd0);
        step("fh_bubble");
        flush = 1'b0;

        // Hold for three cycles with a hazard present.
        set_inputs(7'h05, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
        step("lw8");
        for (int i = 0; i < 3; i++) begin
            set_inputs(7'($urandom), 3'($urandom), 2'($urandom), 5'd8, 5'd8, 5'($urandom));
            enable = 1'b0;
            #1;
            chk("hold_stall", 64'(stall_out), 64'd0);
            step("hold");
            chk("hold_rt_const", 64'(rt_out), 64'd8);
        end
        enable = 1'b1;
        step("hold_release");

        // Asynchronous reset mid-cycle with nonzero outputs.
        set_inputs(7'h45, 3'b010, 2'b01, 5'd3, 5'd3, 5'd3);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        check_outputs("in_rst");
        rst_n = 1'b1;
        set_inputs(7'h12, 3'b000, 2'b01, 5'd3, 5'd3, 5'd3);
        step("post_rst");

`ifdef ID_EX_STALL_CNT_EN
        // Saturation: preset near the top, then two hazard bubbles.
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFE;
        for (int i = 0; i < 2; i++) begin
            set_inputs(7'h05, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
            step("sat_lw");
            set_inputs(7'h01, 3'b000, 2'b01, 5'd5, 5'd2, 5'd4);
            step("sat_bubble");
        end
        chk("sat_const", 64'(stall_count), 64'hFFFF);
`endif

        // Randomized stream against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
